// File: rtl/gpu_pkg.sv
// Types and defaults shared by the warp scheduler and its arbiter.
package gpu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    FETCH,
    ISSUE,
    DONE
  } sched_state_t;

  typedef enum logic [1:0] {
    READY,
    WAITING,
    FINISHED
  } warp_state_t;

  localparam int DEFAULT_PC_BITS = 8;

endpackage : gpu_pkg

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority arbiter: grants the first requester found
// starting one position after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         grant_valid,
  output logic [W-1:0] grant_id
);

  logic [W-1:0] idx;

  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    idx         = '0;
    for (int i = 1; i <= N; i++) begin
      idx = W'((int'(ptr) + i) % N);
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant_id    = idx;
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/warp_scheduler.sv
// Per-core warp scheduler: round-robin selects a READY warp, fetches and issues
// its instruction, and parks warps on memory ops until the LSU reports completion.
module warp_scheduler
  import gpu_pkg::*;
#(
  parameter  int MAX_WARPS        = 4,
  parameter  int THREADS_PER_WARP = 4,
  parameter  int PC_BITS          = DEFAULT_PC_BITS,
  localparam int WID_BITS         = $clog2(MAX_WARPS)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [7:0]                  thread_count,
  output logic                        fetch_req,
  output logic [PC_BITS-1:0]          fetch_pc,
  input  logic                        instr_ready,
  output logic                        issue_valid,
  output logic [WID_BITS-1:0]         issue_warp,
  output logic [THREADS_PER_WARP-1:0] issue_mask,
  input  logic                        decoded_ret,
  input  logic                        decoded_mem,
  input  logic [PC_BITS-1:0]          next_pc,
  input  logic                        mem_done_valid,
  input  logic [WID_BITS-1:0]         mem_done_warp,
  output logic                        done
);

  localparam int NW_BITS = WID_BITS + 1;

  sched_state_t        state_q, state_d;
  logic [WID_BITS-1:0] issue_warp_q, issue_warp_d;
  logic [WID_BITS-1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0]          thread_count_q, thread_count_d;
  logic [NW_BITS-1:0]  num_warps_q, num_warps_d;
  logic [PC_BITS-1:0]  pc_q [MAX_WARPS];
  logic [PC_BITS-1:0]  pc_d [MAX_WARPS];
  warp_state_t         warp_state_q [MAX_WARPS];
  warp_state_t         warp_state_d [MAX_WARPS];

  logic [MAX_WARPS-1:0] ready_vec;
  logic                 any_waiting;
  logic                 grant_valid;
  logic [WID_BITS-1:0]  grant_id;
  logic [8:0]           tc_round;
  logic [8:0]           nw_raw;
  logic [NW_BITS-1:0]   nw_sat;
  logic                 mem_done_ok;

  always_comb begin
    ready_vec   = '0;
    any_waiting = 1'b0;
    for (int w = 0; w < MAX_WARPS; w++) begin
      ready_vec[w] = (warp_state_q[w] == READY);
      if (warp_state_q[w] == WAITING) any_waiting = 1'b1;
    end
  end

  rr_arbiter #(.N(MAX_WARPS)) u_arb (
    .req         (ready_vec),
    .ptr         (rr_ptr_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Warp count rounds up and is formed in 9 bits so thread_count near 255 cannot wrap.
  assign tc_round = {1'b0, thread_count} + 9'(THREADS_PER_WARP - 1);
  assign nw_raw   = tc_round / 9'(THREADS_PER_WARP);
  assign nw_sat   = (nw_raw > 9'(MAX_WARPS)) ? NW_BITS'(MAX_WARPS) : nw_raw[NW_BITS-1:0];

  // Warps beyond the launched count are FINISHED, so bounding by num_warps also rejects ids past MAX_WARPS.
  assign mem_done_ok = mem_done_valid && (state_q != IDLE) &&
                       ({1'b0, mem_done_warp} < num_warps_q);

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (which would infer a latch).
  always_comb begin
    state_d        = state_q;
    issue_warp_d   = issue_warp_q;
    rr_ptr_d       = rr_ptr_q;
    thread_count_d = thread_count_q;
    num_warps_d    = num_warps_q;
    pc_d           = pc_q;
    warp_state_d   = warp_state_q;

    if (mem_done_ok && (warp_state_q[mem_done_warp] == WAITING)) begin
      warp_state_d[mem_done_warp] = READY;
    end

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          thread_count_d = thread_count;
          num_warps_d    = nw_sat;
          // Park the pointer on the last slot so a fresh launch issues warp 0 first.
          rr_ptr_d       = WID_BITS'(MAX_WARPS - 1);
          for (int w = 0; w < MAX_WARPS; w++) begin
            pc_d[w]         = '0;
            warp_state_d[w] = (9'(w) < nw_raw) ? READY : FINISHED;
          end
          state_d = SELECT;
        end
      end
      SELECT: begin
        // Arbitration sees registered states; a same-cycle mem_done wakes its warp one cycle later.
        if (grant_valid) begin
          issue_warp_d = grant_id;
          state_d      = FETCH;
        end else if (!any_waiting) begin
          state_d = DONE;
        end
      end
      FETCH: begin
        if (instr_ready) state_d = ISSUE;
      end
      ISSUE: begin
        rr_ptr_d = issue_warp_q;
        if (decoded_ret) begin
          warp_state_d[issue_warp_q] = FINISHED;
        end else begin
          pc_d[issue_warp_q] = next_pc;
          if (decoded_mem) warp_state_d[issue_warp_q] = WAITING;
        end
        state_d = SELECT;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      issue_warp_q   <= '0;
      rr_ptr_q       <= '0;
      thread_count_q <= '0;
      num_warps_q    <= '0;
      // NOTE: the PC and warp-state arrays are plain flops, not a RAM, so resetting them is cheap and intended.
      for (int w = 0; w < MAX_WARPS; w++) begin
        pc_q[w]         <= '0;
        warp_state_q[w] <= FINISHED;
      end
    end else begin
      state_q        <= state_d;
      issue_warp_q   <= issue_warp_d;
      rr_ptr_q       <= rr_ptr_d;
      thread_count_q <= thread_count_d;
      num_warps_q    <= num_warps_d;
      pc_q           <= pc_d;
      warp_state_q   <= warp_state_d;
    end
  end

  assign fetch_req   = (state_q == FETCH);
  assign fetch_pc    = fetch_req ? pc_q[issue_warp_q] : '0;
  assign issue_valid = (state_q == ISSUE);
  assign issue_warp  = issue_warp_q;
  assign done        = (state_q == DONE);

  always_comb begin
    issue_mask = '0;
    for (int t = 0; t < THREADS_PER_WARP; t++) begin
      issue_mask[t] = (16'(issue_warp_q) * 16'(THREADS_PER_WARP) + 16'(t)) < {8'd0, thread_count_q};
    end
  end

endmodule : warp_scheduler

// File: tb/tb_warp_scheduler.sv
// Directed bench for warp_scheduler: a table of per-instruction issue records
// plus hand sequences for launch latency, stalls, wake-up timing and reset.
module tb_warp_scheduler;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] thread_count;
  logic       fetch_req;
  logic [7:0] fetch_pc;
  logic       instr_ready;
  logic       issue_valid;
  logic [1:0] issue_warp;
  logic [3:0] issue_mask;
  logic       decoded_ret;
  logic       decoded_mem;
  logic [7:0] next_pc;
  logic       mem_done_valid;
  logic [1:0] mem_done_warp;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  warp_scheduler dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .thread_count   (thread_count),
    .fetch_req      (fetch_req),
    .fetch_pc       (fetch_pc),
    .instr_ready    (instr_ready),
    .issue_valid    (issue_valid),
    .issue_warp     (issue_warp),
    .issue_mask     (issue_mask),
    .decoded_ret    (decoded_ret),
    .decoded_mem    (decoded_mem),
    .next_pc        (next_pc),
    .mem_done_valid (mem_done_valid),
    .mem_done_warp  (mem_done_warp),
    .done           (done)
  );

  // One record per issued instruction: expected fetch, stall length, and decoder/LSU stimulus.
  typedef struct {
    logic [1:0] warp;
    logic [7:0] pc;
    logic [3:0] mask;
    int         wait_cyc;
    logic       ret;
    logic       mem;
    logic [7:0] npc;
    logic       md_v;
    logic [1:0] md_w;
  } issue_vec_t;

  issue_vec_t vecs[$];

  function automatic issue_vec_t mk(input logic [1:0] warp, input logic [7:0] pc,
                                    input logic [3:0] mask, input int wait_cyc,
                                    input logic ret, input logic mem, input logic [7:0] npc,
                                    input logic md_v, input logic [1:0] md_w);
    issue_vec_t v;
    v.warp = warp; v.pc = pc; v.mask = mask; v.wait_cyc = wait_cyc;
    v.ret = ret; v.mem = mem; v.npc = npc; v.md_v = md_v; v.md_w = md_w;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic launch(input logic [7:0] tc, input logic expect_warps);
    @(negedge clk);
    start = 1'b1;
    thread_count = tc;
    @(negedge clk);
    start = 1'b0;
    check($sformatf("launch%0d select fetch_req", tc), fetch_req, 0);
    check($sformatf("launch%0d select done", tc), done, 0);
    @(negedge clk);
    check($sformatf("launch%0d latency fetch_req", tc), fetch_req, expect_warps);
    check($sformatf("launch%0d latency done", tc), done, !expect_warps);
  endtask

  task automatic wait_fetch(input string name);
    int n = 0;
    while (!fetch_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, " fetch_req"}, fetch_req, 1);
  endtask

  task automatic run_vec(input int idx);
    issue_vec_t v = vecs[idx];
    string nm = $sformatf("v%0d", idx);
    wait_fetch(nm);
    check({nm, " issue_warp"}, issue_warp, v.warp);
    check({nm, " fetch_pc"}, fetch_pc, v.pc);
    check({nm, " issue_mask"}, issue_mask, v.mask);
    for (int i = 0; i < v.wait_cyc; i++) begin
      @(negedge clk);
      check({nm, " stall fetch_req"}, fetch_req, 1);
      check({nm, " stall issue_valid"}, issue_valid, 0);
    end
    instr_ready = 1'b1;
    decoded_ret = v.ret;
    decoded_mem = v.mem;
    next_pc = v.npc;
    mem_done_valid = v.md_v;
    mem_done_warp = v.md_w;
    @(negedge clk);
    instr_ready = 1'b0;
    mem_done_valid = 1'b0;
    check({nm, " issue_valid"}, issue_valid, 1);
    check({nm, " issue fetch_req"}, fetch_req, 0);
    check({nm, " issue_warp held"}, issue_warp, v.warp);
    @(negedge clk);
    decoded_ret = 1'b0;
    decoded_mem = 1'b0;
    check({nm, " post issue_valid"}, issue_valid, 0);
  endtask

  task automatic run_rows(input int first, input int last);
    for (int i = first; i <= last; i++) run_vec(i);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({name, " done"}, done, 1);
    check({name, " done fetch_req"}, fetch_req, 0);
  endtask

  initial begin
    // Scenario A: thread_count=8, two warps alternate, RET each at the end (rows 0..7)
    vecs.push_back(mk(2'd0, 8'd0, 4'hF, 0, 0, 0, 8'd1, 0, 2'd0));
    vecs.push_back(mk(2'd1, 8'd0, 4'hF, 2, 0, 0, 8'd1, 0, 2'd0));
    vecs.push_back(mk(2'd0, 8'd1, 4'hF, 0, 0, 0, 8'd2, 0, 2'd0));
    vecs.push_back(mk(2'd1, 8'd1, 4'hF, 0, 0, 0, 8'd2, 0, 2'd0));
    vecs.push_back(mk(2'd0, 8'd2, 4'hF, 0, 0, 0, 8'd3, 0, 2'd0));
    vecs.push_back(mk(2'd1, 8'd2, 4'hF, 0, 0, 0, 8'd3, 0, 2'd0));
    vecs.push_back(mk(2'd0, 8'd3, 4'hF, 0, 1, 0, 8'd0, 0, 2'd0));
    vecs.push_back(mk(2'd1, 8'd3, 4'hF, 0, 1, 0, 8'd0, 0, 2'd0));
    // Scenario B: thread_count=6, partial mask; stray mem_done on finished warp 0 (rows 8..9)
    vecs.push_back(mk(2'd0, 8'd0, 4'hF, 0, 1, 0, 8'd0, 0, 2'd0));
    vecs.push_back(mk(2'd1, 8'd0, 4'h3, 0, 1, 0, 8'd0, 1, 2'd0));
    // Scenario C: thread_count=16, warp 0 parks on a memory op (rows 10..20)
    vecs.push_back(mk(2'd0, 8'd0,  4'hF, 0, 0, 1, 8'h10, 0, 2'd0));
    vecs.push_back(mk(2'd1, 8'd0,  4'hF, 0, 0, 0, 8'd5,  0, 2'd0));
    vecs.push_back(mk(2'd2, 8'd0,  4'hF, 0, 0, 0, 8'd5,  0, 2'd0));
    vecs.push_back(mk(2'd3, 8'd0,  4'hF, 0, 0, 0, 8'd5,  0, 2'd0));
    vecs.push_back(mk(2'd1, 8'd5,  4'hF, 0, 0, 0, 8'd6,  1, 2'd0));
    vecs.push_back(mk(2'd2, 8'd5,  4'hF, 0, 0, 0, 8'd6,  0, 2'd0));
    vecs.push_back(mk(2'd3, 8'd5,  4'hF, 0, 0, 0, 8'd6,  0, 2'd0));
    vecs.push_back(mk(2'd0, 8'h10, 4'hF, 0, 1, 0, 8'd0,  0, 2'd0));
    vecs.push_back(mk(2'd1, 8'd6,  4'hF, 0, 1, 0, 8'd0,  0, 2'd0));
    vecs.push_back(mk(2'd2, 8'd6,  4'hF, 0, 1, 0, 8'd0,  0, 2'd0));
    vecs.push_back(mk(2'd3, 8'd6,  4'hF, 0, 1, 0, 8'd0,  0, 2'd0));
    // Scenario D: thread_count=12, every warp waits; warp 2 woken first (rows 21..24)
    vecs.push_back(mk(2'd0, 8'd0, 4'hF, 0, 0, 1, 8'd7, 0, 2'd0));
    vecs.push_back(mk(2'd1, 8'd0, 4'hF, 0, 0, 1, 8'd8, 0, 2'd0));
    vecs.push_back(mk(2'd2, 8'd0, 4'hF, 0, 0, 1, 8'd9, 0, 2'd0));
    vecs.push_back(mk(2'd2, 8'd9, 4'hF, 0, 1, 0, 8'd0, 0, 2'd0));
    // Scenario E: fresh launch after reset, thread_count=8 (rows 25..26)
    vecs.push_back(mk(2'd0, 8'd0, 4'hF, 0, 1, 0, 8'd0, 0, 2'd0));
    vecs.push_back(mk(2'd1, 8'd0, 4'hF, 0, 1, 0, 8'd0, 0, 2'd0));
    // Scenarios F/G: thread_count=200 and 255 saturate to four warps (rows 27..30, reused)
    vecs.push_back(mk(2'd0, 8'd0, 4'hF, 0, 1, 0, 8'd0, 0, 2'd0));
    vecs.push_back(mk(2'd1, 8'd0, 4'hF, 0, 1, 0, 8'd0, 0, 2'd0));
    vecs.push_back(mk(2'd2, 8'd0, 4'hF, 0, 1, 0, 8'd0, 0, 2'd0));
    vecs.push_back(mk(2'd3, 8'd0, 4'hF, 0, 1, 0, 8'd0, 0, 2'd0));

    reset_n = 1'b0;
    start = 1'b0;
    thread_count = '0;
    instr_ready = 1'b0;
    decoded_ret = 1'b0;
    decoded_mem = 1'b0;
    next_pc = '0;
    mem_done_valid = 1'b0;
    mem_done_warp = '0;

    repeat (2) @(negedge clk);
    check("reset fetch_req", fetch_req, 0);
    check("reset issue_valid", issue_valid, 0);
    check("reset done", done, 0);
    check("reset fetch_pc", fetch_pc, 0);
    check("reset issue_warp", issue_warp, 0);
    check("reset issue_mask", issue_mask, 0);
    reset_n = 1'b1;

    // Start is ignored-free in IDLE: nothing happens without it
    @(negedge clk);
    check("idle fetch_req", fetch_req, 0);

    launch(8'd8, 1'b1);
    run_rows(0, 7);
    wait_done("A");

    launch(8'd6, 1'b1);
    run_rows(8, 9);
    wait_done("B");

    launch(8'd0, 1'b0);
    repeat (2) begin
      @(negedge clk);
      check("tc0 done held", done, 1);
      check("tc0 no fetch", fetch_req, 0);
    end

    launch(8'd16, 1'b1);
    run_rows(10, 20);
    wait_done("C");

    launch(8'd12, 1'b1);
    run_rows(21, 23);
    repeat (4) begin
      @(negedge clk);
      check("all waiting fetch_req", fetch_req, 0);
      check("all waiting done", done, 0);
    end
    mem_done_valid = 1'b1;
    mem_done_warp = 2'd2;
    @(negedge clk);
    mem_done_valid = 1'b0;
    check("wake same-cycle fetch_req", fetch_req, 0);
    run_rows(24, 24);

    // Wake warp 0, then stall it in FETCH, try a start there, and reset mid-fetch
    mem_done_valid = 1'b1;
    mem_done_warp = 2'd0;
    @(negedge clk);
    mem_done_valid = 1'b0;
    wait_fetch("D wake0");
    check("D wake0 issue_warp", issue_warp, 0);
    check("D wake0 fetch_pc", fetch_pc, 8'd7);
    start = 1'b1;
    thread_count = 8'd0;
    @(negedge clk);
    start = 1'b0;
    check("fetch start ignored fetch_req", fetch_req, 1);
    check("fetch start ignored done", done, 0);
    #2 reset_n = 1'b0;
    #1;
    check("midreset fetch_req", fetch_req, 0);
    check("midreset fetch_pc", fetch_pc, 0);
    check("midreset issue_valid", issue_valid, 0);
    check("midreset issue_warp", issue_warp, 0);
    check("midreset issue_mask", issue_mask, 0);
    check("midreset done", done, 0);
    @(negedge clk);
    reset_n = 1'b1;

    launch(8'd8, 1'b1);
    run_rows(25, 26);
    wait_done("E");

    launch(8'd200, 1'b1);
    run_rows(27, 30);
    wait_done("F");

    launch(8'd255, 1'b1);
    run_rows(27, 30);
    wait_done("G");
    mem_done_valid = 1'b1;
    mem_done_warp = 2'd1;
    repeat (3) begin
      @(negedge clk);
      check("G done held", done, 1);
    end
    mem_done_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Backstop so a stuck handshake can never hang the run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected test to finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_warp_scheduler
